// File: rtl/mem_port.sv
// Memory access unit: turns controller fetch/load/store intent into a req/ack bus
// transaction and owns IR/MDR. Define MEMPORT_TIMEOUT_EN to abort stalled accesses.
module mem_port #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              IorD,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] MDR,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Handshake: mem_req/mem_we/mem_addr/mem_wdata are held stable from the cycle
    // after start is accepted until the edge that samples mem_ack high; mem_ack is
    // a one-cycle pulse with mem_rdata valid in that same cycle, and is ignored
    // whenever no request is outstanding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_sel;
    logic              misaligned;
    logic              dest_ir;
    logic              timeout_hit;

    assign addr_sel   = IorD ? alu_out : pc;
    assign misaligned = (addr_sel[1:0] != 2'b00);

`ifdef MEMPORT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    // Counter sits at zero outside BUS, so it is clear on every BUS entry.
    always_ff @(posedge clk) begin
        if (rst || state != BUS) begin
            to_cnt <= '0;
        end else if (!mem_ack) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout the bus waits forever; the parameter is inert.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = misaligned ? DONE : BUS;
            BUS:     if (mem_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dest_ir   <= 1'b0;
            IR        <= '0;
            MDR       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr  <= addr_sel;
                        mem_wdata <= wdata;
                        dest_ir   <= IRWrite;
                        if (misaligned) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            mem_req <= 1'b1;
                            mem_we  <= MemWrite;
                        end
                    end
                end
                BUS: begin
                    // An ack on the timeout cycle still counts as a normal completion.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        if (!mem_we) begin
                            if (dest_ir) IR <= mem_rdata;
                            else         MDR <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: doc/mem_port.md
Name: mem_port

Overview:
- Memory access unit directly downstream of the multicycle controller.
- Turns the controller's IorD/MemWrite/IRWrite intent into a registered request/acknowledge transaction on a unified variable-latency memory bus.
- Owns the instruction register (IR) and memory data register (MDR).
- Gives the controller busy/done status so the FSM can hold in IF/MEM until the access completes.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width (word accesses only)
TIMEOUT_CYCLES, 16, max cycles in BUS before abort (used only with MEMPORT_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  access request from controller, level; sampled only in IDLE
IorD  in  1  0: address = pc; 1: address = alu_out
MemWrite  in  1  1: write access; 0: read access
IRWrite  in  1  read destination: 1 = IR, 0 = MDR; ignored for writes
pc  in  ADDR_W  program counter
alu_out  in  ADDR_W  ALUOut register (data address)
wdata  in  DATA_W  store data (rt read data)
mem_req  out  1  bus request, held until ack
mem_we  out  1  bus write enable
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_ack  in  1  bus acknowledge, one-cycle pulse; rdata valid in same cycle
mem_rdata  in  DATA_W  bus read data
IR  out  DATA_W  instruction register
MDR  out  DATA_W  memory data register
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done: misaligned address or timeout

Behaviour:
- Reset (synchronous, on clk edge with rst=1): state=IDLE; all outputs 0; IR=0, MDR=0.
- Reset mid-transaction: mem_req drops at that same edge; no IR/MDR load; no done pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE, start=1:
  - Capture addr = IorD ? alu_out : pc.
  - Capture we = MemWrite, dest = IRWrite, data = wdata.
  - If addr[1:0] != 0: go to DONE with err=1; no bus transaction.
  - Otherwise: go to BUS; mem_req=1 from the next cycle.
- IDLE, start=0: stay in IDLE. A mem_ack in IDLE is ignored.
- BUS:
  - mem_req/mem_we/mem_addr/mem_wdata stay stable every cycle until mem_ack is sampled high.
  - On the mem_ack edge: mem_req and mem_we go 0.
  - For a read, load IR (dest=1) or MDR (dest=0) from mem_rdata at the ack edge.
  - For a write, IR and MDR are unchanged.
  - Then go to DONE with err=0.
- DONE: done=1 for exactly one cycle; err held for that cycle; go to IDLE. start is not accepted in DONE.
- start while busy is ignored; the controller re-asserts it after done.
- Latency:
  - Edge E0 samples start → mem_req high in cycle after E0.
  - ack sampled at edge E0+k (k≥1) → done high in cycle after E0+k.
  - Zero-wait memory gives start→done of 2 edges.
  - Misaligned access gives done in the cycle after E0.
- IR and MDR hold their value indefinitely between loads; they are never cleared except by rst.
- State encoding: IDLE, BUS, DONE (2 bits); all others go to IDLE.

Optional Feature:
MEMPORT_TIMEOUT_EN
- Defined:
  - A counter clears on BUS entry and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: drop mem_req, go to DONE with err=1, no register load.
  - An ack in the same cycle the count is reached takes priority (normal completion).
  - A late ack arriving after abort is ignored.
- Undefined: no counter; BUS waits indefinitely for mem_ack.

Test Plan:
- Fetch, zero-wait: rst → start=1, IorD=0, IRWrite=1, pc=0x0000_0040; ack the first req cycle with rdata=0x2008_0005 → mem_addr=0x40, IR=0x2008_0005, MDR=0, done one cycle, err=0, 2 edges total.
- Load, 3 wait cycles: IorD=1, IRWrite=0, alu_out=0x0000_1004; ack after 3 req cycles, rdata=0xDEAD_BEEF → addr/req stable for 4 cycles, MDR=0xDEAD_BEEF, IR unchanged.
- Store: MemWrite=1, alu_out=0x100, wdata=0x1234_5678 → mem_we=1, mem_wdata=0x1234_5678 until ack; IR/MDR unchanged; done=1, err=0.
- Misaligned: IorD=1, alu_out=0x0000_1002 → mem_req never asserted; done=1, err=1 next cycle.
- Protocol edges:
  - Spurious ack in IDLE → no register change.
  - start held high through BUS → no second transaction until IDLE.
  - rst asserted in BUS → mem_req=0 and IR=MDR=0 after that edge, no done.
- With MEMPORT_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack:
  - req high 4 cycles → done=1, err=1; later ack ignored.
  - Ack in the 4th cycle completes normally with err=0.
